// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports, one synchronous write port.
// r0 has no storage and always reads zero.
module regfile (
   input  logic        Clk,
   input  logic        Reset,
   output logic [31:0] ReadData1,
   output logic [31:0] ReadData2,
   input  logic [31:0] WriteData,
   input  logic [4:0]  ReadRegister1,
   input  logic [4:0]  ReadRegister2,
   input  logic [4:0]  WriteRegister,
   input  logic        RegWrite
);

   logic [31:0] regs [1:31];
   logic [31:1] load;
   logic [31:0] bank [0:31];

   assign bank[0] = '0;

   for (genvar g = 1; g < 32; g++) begin : g_reg
      // One-hot write decode; address 0 has no slot so its writes vanish.
      assign load[g] = RegWrite && (WriteRegister == 5'(g));

      always_ff @(posedge Clk) begin
         if (Reset)
            regs[g] <= '0;
         else if (load[g])
            regs[g] <= WriteData;
      end

      assign bank[g] = regs[g];
   end

   assign ReadData1 = bank[ReadRegister1];
   assign ReadData2 = bank[ReadRegister2];

endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: a reference register array feeds a queue of
// expected read values that is drained at every check point.
module tb_regfile;

   logic        Clk = 1'b0;
   logic        Reset;
   logic [31:0] ReadData1;
   logic [31:0] ReadData2;
   logic [31:0] WriteData;
   logic [4:0]  ReadRegister1;
   logic [4:0]  ReadRegister2;
   logic [4:0]  WriteRegister;
   logic        RegWrite;

   logic [31:0] mdl [0:31];
   logic [31:0] sb [$];
   int          n_cmp = 0;
   int          n_bad = 0;

   regfile dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .ReadData1     (ReadData1),
      .ReadData2     (ReadData2),
      .WriteData     (WriteData),
      .ReadRegister1 (ReadRegister1),
      .ReadRegister2 (ReadRegister2),
      .WriteRegister (WriteRegister),
      .RegWrite      (RegWrite)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic cmp(input string tag, input logic [31:0] obs);
      logic [31:0] exp;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
      end else begin
         exp = sb.pop_front();
         assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
      end
   endtask

   task automatic push_reads(input logic [4:0] a1, input logic [4:0] a2);
      sb.push_back(mdl[a1]);
      sb.push_back(mdl[a2]);
   endtask

   task automatic check_reads(input string tag);
      cmp({tag, "_rd1"}, ReadData1);
      cmp({tag, "_rd2"}, ReadData2);
   endtask

   // Change read addresses only, no clock.
   task automatic peek(input string tag, input logic [4:0] a1,
                       input logic [4:0] a2);
      ReadRegister1 = a1;
      ReadRegister2 = a2;
      #1;
      push_reads(a1, a2);
      check_reads(tag);
   endtask

   // One clocked cycle; pre=1 also checks the old value is seen before the edge.
   task automatic step(input string tag, input bit pre, input logic rst,
                       input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a1,
                       input logic [4:0] a2);
      @(negedge Clk);
      Reset = rst;
      RegWrite = we;
      WriteRegister = wa;
      WriteData = wd;
      ReadRegister1 = a1;
      ReadRegister2 = a2;
      #1;
      if (pre) begin
         push_reads(a1, a2);
         check_reads({tag, "_pre"});
      end
      if (rst) begin
         for (int i = 0; i < 32; i++) mdl[i] = '0;
      end else if (we && wa != 5'd0) begin
         mdl[wa] = wd;
      end
      push_reads(a1, a2);
      @(posedge Clk);
      #1;
      check_reads(tag);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mdl[i] = 'x;
      mdl[0] = '0;
      Reset = 1'b1;
      RegWrite = 1'b0;
      WriteRegister = '0;
      WriteData = '0;
      ReadRegister1 = '0;
      ReadRegister2 = '0;

      step("reset", 1'b0, 1'b1, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31);
      for (int i = 0; i < 32; i++)
         peek("reset_all", 5'(i), 5'(31 - i));

      step("r2_42", 1'b1, 1'b0, 1'b1, 5'd2, 32'd42, 5'd2, 5'd2);
      step("r2_15", 1'b1, 1'b0, 1'b1, 5'd2, 32'd15, 5'd2, 5'd2);

      for (int i = 1; i < 32; i++)
         step("fill", 1'b1, 1'b0, 1'b1, 5'(i), 32'd283492, 5'(i), 5'(i));

      for (int i = 1; i < 32; i++)
         step("we_off", 1'b1, 1'b0, 1'b0, 5'(i), 32'd9834, 5'(i), 5'(i));

      step("r11_299", 1'b1, 1'b0, 1'b1, 5'd11, 32'd299, 5'd16, 5'd18);
      peek("rd2_r11", 5'd16, 5'd11);
      peek("rd2_r18", 5'd16, 5'd18);
      peek("split", 5'd11, 5'd10);

      step("r0_write", 1'b1, 1'b0, 1'b1, 5'd0, 32'd9999, 5'd0, 5'd0);

      step("r31_edge", 1'b1, 1'b0, 1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd30);
      step("r1_edge", 1'b1, 1'b0, 1'b1, 5'd1, 32'hA5A5_5A5A, 5'd1, 5'd31);

      for (int i = 0; i < 6; i++)
         step("rand", 1'b1, 1'b0, 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 31)), $urandom,
              5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));

      step("rst_vs_wr", 1'b1, 1'b1, 1'b1, 5'd5, 32'd7, 5'd5, 5'd11);
      for (int i = 0; i < 32; i++)
         peek("post_rst", 5'(i), 5'(31 - i));

      step("resume", 1'b1, 1'b0, 1'b1, 5'd5, 32'd7, 5'd5, 5'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
